// File: rtl/uart_rx_ovs_if.sv
// uart_rx_ovs_if: byte delivery and status bundle of the oversampling UART receiver.
//   data_out[7:0] : received byte, stable while valid is high
//   valid / ready : the consumer takes the byte when valid && ready
//   frame_err     : one-cycle pulse, stop bit sampled low
//   overrun       : one-cycle pulse, good byte dropped because the previous one was still pending
//   parity_err    : one-cycle pulse on even-parity mismatch (present only with UART_RX_PARITY_EN)
//   busy          : receiver is inside a frame
//   modport master = receiver side, modport slave = consumer side
interface uart_rx_ovs_if;
    logic [7:0] data_out;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    modport master (output data_out, valid, frame_err, overrun, busy, parity_err, input ready);
    modport slave  (input data_out, valid, frame_err, overrun, busy, parity_err, output ready);
`else
    modport master (output data_out, valid, frame_err, overrun, busy, input ready);
    modport slave  (input data_out, valid, frame_err, overrun, busy, output ready);
`endif
endinterface

// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs: 16x oversampling UART receiver with majority voting and valid/ready byte output.
//   clk   : system clock, single domain, rising edge
//   reset : synchronous, active-high
//   rx    : asynchronous serial line, idles high
//   rxo   : uart_rx_ovs_if.master (data_out, valid, ready, frame_err, overrun, busy[, parity_err])
//   Optional even-parity bit between data and stop is compiled in with UART_RX_PARITY_EN.
module uart_rx_ovs #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int OVS_DIV  = CLK_FREQ / (BAUD * 16)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx,
    uart_rx_ovs_if.master rxo
);
    localparam int            CW       = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(OVS_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

`ifdef UART_RX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif

    state_t        state_q, state_d;
    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    phase_q, phase_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          s7_q, s7_d;
    logic          s8_q, s8_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
    logic          par_q, par_d;
    logic          perr_q, perr_d;
`endif

    logic rx_s, tick, maj, mid, last;

    assign rx_s = sync_q[1];
    assign tick = (state_q != IDLE) && (cnt_q == CNT_LAST);
    // Vote over the phase-7/8 samples and the live phase-9 value.
    assign maj  = (s7_q & s8_q) | (s7_q & rx_s) | (s8_q & rx_s);
    assign mid  = tick && (phase_q == 4'd9);
    assign last = tick && (phase_q == 4'd15);

    always_comb begin
        sync_d  = {sync_q[0], rx};
        state_d = state_q;
        cnt_d   = (state_q == IDLE || tick) ? '0 : cnt_q + 1'b1;
        phase_d = tick ? phase_q + 4'd1 : phase_q;
        s7_d    = (tick && phase_q == 4'd7) ? rx_s : s7_q;
        s8_d    = (tick && phase_q == 4'd8) ? rx_s : s8_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q && !rxo.ready;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    phase_d = '0;
                end
            end
            START: begin
                if (mid && maj) begin
                    state_d = IDLE;
                end else if (last) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (mid) shift_d = {maj, shift_q[7:1]};
                if (last) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = AFTER_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (mid) par_d = maj;
                if (last) state_d = STOP;
            end
`endif
            STOP: begin
                // Leave at the stop-bit decision so a following start edge is never missed.
                if (mid) begin
                    state_d = IDLE;
                    if (!maj) begin
                        ferr_d = 1'b1;
                    end
`ifdef UART_RX_PARITY_EN
                    else if (^{shift_q, par_q}) begin
                        perr_d = 1'b1;
                    end
`endif
                    else if (!valid_q || rxo.ready) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            phase_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            s7_q    <= 1'b0;
            s8_q    <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            s7_q    <= s7_d;
            s8_q    <= s8_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign rxo.data_out  = data_q;
    assign rxo.valid     = valid_q;
    assign rxo.frame_err = ferr_q;
    assign rxo.overrun   = ovr_q;
    assign rxo.busy      = state_q != IDLE;
`ifdef UART_RX_PARITY_EN
    assign rxo.parity_err = perr_q;
`endif
endmodule

// File: tb/tb_uart_rx_ovs.sv
// tb_uart_rx_ovs: directed and random frames against a frame-level timing model of the receiver.
module tb_uart_rx_ovs;
    localparam int D    = 4;
    localparam int BITC = 16 * D;
`ifdef UART_RX_PARITY_EN
    localparam int STOPN = 10;
`else
    localparam int STOPN = 9;
`endif
    localparam int EVAL = 16 * STOPN + 10;
    localparam int HN   = 65536;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx = 1'b1;
    logic ready = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    uart_rx_ovs_if bus ();
    assign bus.ready = ready;

    uart_rx_ovs #(.OVS_DIV(D)) dut (
        .clk(clk),
        .reset(reset),
        .rx(rx),
        .rxo(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bit         pin_h [HN];
    bit         rxs_h [HN];
    logic [7:0] e_data = 8'h00;
    logic       e_valid = 1'b0, e_fe = 1'b0, e_ov = 1'b0, e_pe = 1'b0, e_busy = 1'b0;
    bit         m_ok = 1'b0, m_busy = 1'b0;
    int         t0 = 0, rst_last = 0;
    int         n_fe = 0, n_ov = 0, n_pe = 0, last_rise = -1, last_start = 0;
    logic       prev_v = 1'b0;
    logic [7:0] got [$];
    bit         rdy_rand = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    // Majority of the synchronised line at phases 7, 8, 9 of bit n of the frame starting at t.
    function automatic logic maj(input int t, input int n);
        int   b;
        logic a0, a1, a2;
        b  = t + (16 * n + 8) * D;
        a0 = rxs_h[b];
        a1 = rxs_h[b + D];
        a2 = rxs_h[b + 2 * D];
        return (a0 & a1) | (a0 & a2) | (a1 & a2);
    endfunction

    always @(negedge clk) begin
        logic       rxs, nv, nfe, nov, npe, stop_b, par_ok;
        logic [7:0] nd, d;
        if (m_ok) begin
            chk("valid", bus.valid, e_valid);
            chk("data_out", bus.data_out, e_data);
            chk("frame_err", bus.frame_err, e_fe);
            chk("overrun", bus.overrun, e_ov);
            chk("busy", bus.busy, e_busy);
`ifdef UART_RX_PARITY_EN
            chk("parity_err", bus.parity_err, e_pe);
`endif
        end
        if (bus.valid === 1'b1 && ready === 1'b1) got.push_back(bus.data_out);
        if (bus.valid === 1'b1 && prev_v !== 1'b1) last_rise = cyc;
        prev_v = bus.valid;
        if (bus.frame_err === 1'b1) n_fe++;
        if (bus.overrun === 1'b1) n_ov++;
`ifdef UART_RX_PARITY_EN
        if (bus.parity_err === 1'b1) n_pe++;
`endif
        if (cyc < HN) begin
            pin_h[cyc] = rx;
            rxs = (cyc < 2 || cyc <= rst_last + 2) ? 1'b1 : pin_h[cyc - 2];
            rxs_h[cyc] = rxs;
            nv  = e_valid && !ready;
            nd  = e_data;
            nfe = 1'b0;
            nov = 1'b0;
            npe = 1'b0;
            if (reset) begin
                rst_last = cyc;
                m_ok     = 1'b1;
                m_busy   = 1'b0;
                nv       = 1'b0;
                nd       = 8'h00;
            end else if (!m_busy) begin
                if (!rxs) begin
                    m_busy = 1'b1;
                    t0     = cyc;
                end
            end else if (cyc == t0 + 10 * D) begin
                if (maj(t0, 0)) m_busy = 1'b0;
            end else if (cyc == t0 + EVAL * D) begin
                m_busy = 1'b0;
                for (int i = 0; i < 8; i++) d[i] = maj(t0, i + 1);
                stop_b = maj(t0, STOPN);
`ifdef UART_RX_PARITY_EN
                par_ok = (^d) == maj(t0, 9);
`else
                par_ok = 1'b1;
`endif
                if (!stop_b) nfe = 1'b1;
                else if (!par_ok) npe = 1'b1;
                else if (!e_valid || ready) begin
                    nv = 1'b1;
                    nd = d;
                end else nov = 1'b1;
            end
            e_valid = nv;
            e_data  = nd;
            e_fe    = nfe;
            e_ov    = nov;
            e_pe    = npe;
            e_busy  = m_busy;
        end
    end

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop_v, input logic par_flip, input int gap);
        last_start = cyc;
        hold(1'b0, BITC);
        for (int i = 0; i < 8; i++) hold(b[i], BITC);
`ifdef UART_RX_PARITY_EN
        hold((^b) ^ par_flip, BITC);
`endif
        hold(stop_v, BITC);
        if (gap > 0) hold(1'b1, gap);
    endtask

    task automatic pop_chk(input string nm, input logic [7:0] v);
        chk(nm, got.size() > 0 ? {24'd0, got.pop_front()} : 32'hdead, {24'd0, v});
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #3_000_000;
        bad++;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int fe0, ov0, pe0, sz0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        ready = 1'b1;
        chk("reset_data", bus.data_out, 8'h00);
        chk("reset_busy", bus.busy, 1'b0);
        hold(1'b1, 20);

        send(8'hA5, 1'b1, 1'b0, 2 * BITC);
        chk("a5_latency", last_rise, last_start + 2 + EVAL * D + 1);
        pop_chk("a5_byte", 8'hA5);
        chk("a5_no_err", n_fe + n_ov + n_pe, 0);

        fe0 = n_fe;
        hold(1'b0, 4);
        hold(1'b1, 12 * BITC);
        chk("glitch_no_byte", got.size(), 0);
        chk("glitch_no_err", n_fe, fe0);

        send(8'h3C, 1'b0, 1'b0, 2 * BITC);
        chk("fe_pulse", n_fe, fe0 + 1);
        chk("fe_no_byte", got.size(), 0);
        send(8'h81, 1'b1, 1'b0, 2 * BITC);
        pop_chk("after_fe_byte", 8'h81);

        ready = 1'b0;
        ov0 = n_ov;
        send(8'h11, 1'b1, 1'b0, BITC);
        send(8'h22, 1'b1, 1'b0, BITC);
        chk("ovr_pulse", n_ov, ov0 + 1);
        chk("ovr_valid", bus.valid, 1'b1);
        chk("ovr_data", bus.data_out, 8'h11);
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
        chk("ovr_cleared", bus.valid, 1'b0);
        pop_chk("ovr_kept", 8'h11);
        ready = 1'b1;

        send(8'h00, 1'b1, 1'b0, 0);
        send(8'hFF, 1'b1, 1'b0, 0);
        send(8'h55, 1'b1, 1'b0, 2 * BITC);
        pop_chk("b2b_0", 8'h00);
        pop_chk("b2b_1", 8'hFF);
        pop_chk("b2b_2", 8'h55);

        fe0 = n_fe;
        fork
            send(8'hF3, 1'b1, 1'b0, 2 * BITC);
            begin
                repeat ((16 * 5 + 8) * D) @(posedge clk);
                #1;
                reset = 1'b1;
                @(posedge clk);
                #1;
                reset = 1'b0;
                chk("midrst_busy", bus.busy, 1'b0);
                chk("midrst_data", bus.data_out, 8'h00);
            end
        join
        chk("midrst_no_byte", got.size(), 0);
        chk("midrst_no_err", n_fe, fe0);
        send(8'h7E, 1'b1, 1'b0, 2 * BITC);
        pop_chk("after_rst_byte", 8'h7E);

`ifdef UART_RX_PARITY_EN
        pe0 = n_pe;
        send(8'h07, 1'b1, 1'b1, 2 * BITC);
        chk("par_err_pulse", n_pe, pe0 + 1);
        chk("par_err_no_byte", got.size(), 0);
        send(8'h07, 1'b1, 1'b0, 2 * BITC);
        pop_chk("par_ok_byte", 8'h07);
`else
        pe0 = 0;
`endif

        sz0 = pe0;
        got.delete();
        rdy_rand = 1'b1;
        for (int k = 0; k < 24; k++) begin
            send(8'($urandom), ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0),
                 $urandom_range(0, 3 * BITC));
            sz0++;
        end
        hold(1'b1, 2 * BITC);
        rdy_rand = 1'b0;
        #1;
        ready = 1'b1;
        hold(1'b1, 4 * BITC);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_ovs.md
# uart_rx_ovs

Oversampling UART receive front-end for the board-level UART. It synchronises the asynchronous `rx` pin, qualifies start bits, majority-samples each bit at 16x baud, and checks the stop bit. Good bytes are delivered on a valid/ready handshake. Framing and overrun events are flagged so the LED/console logic can drop or report bad characters.

## Interface
- `CLK_FREQ`, 50_000_000, system clock frequency in Hz
- `BAUD`, 115200, line rate in bit/s
- `OVS_DIV`, CLK_FREQ/(BAUD*16) (truncated; 27 at defaults), clocks per oversample tick; must be ≥ 2
- `clk` input 1: system clock; one clock domain, all logic on its rising edge
- `reset` input 1: synchronous, active-high reset
- `rx` input 1: asynchronous serial line; idles high
- `data_out` output 8: received byte, stable while `valid` is high
- `valid` output 1: byte available
- `ready` input 1: consumer accepts the byte when `valid && ready`
- `frame_err` output 1: one-cycle pulse when the stop bit samples low
- `overrun` output 1: one-cycle pulse when a good byte completes while the previous byte is still unaccepted
- `busy` output 1: high whenever the state is not IDLE

## Operation
- `rx` passes through a 2-flop synchroniser. Its flops reset to 1. Only the synchronised signal `rx_s` is used.
- Oversample divider:
  - Counts 0..OVS_DIV-1 and emits a one-cycle `tick` at count OVS_DIV-1.
  - Cleared to 0 in the cycle a start edge is detected.
  - Idle in the IDLE state.
- A 4-bit tick phase counter (0..15) runs per bit. A bit-index counter selects the data bit (0..7).
- Bit value = majority of `rx_s` at phases 7, 8, 9. The decision is taken at the tick of phase 9.
- States:
  - IDLE: when `rx_s`=0, clear the divider and phase, then go to START.
  - START: at the phase-9 decision, a majority of 1 is a false start and returns to IDLE. Otherwise stay until phase 15 ends, then go to DATA.
  - DATA: 8 bits, LSB first, shifted into a holding register. After the phase-15 tick of bit 7, go to PARITY (if compiled in) or STOP.
  - PARITY: sample the bit, then go to STOP after phase 15.
  - STOP: at the phase-9 decision, evaluate the frame and go straight to IDLE. Phases 10–15 are not waited for, so back-to-back frames are accepted.
- Frame evaluation at the STOP decision:
  - Stop bit = 0: pulse `frame_err`. The byte is discarded.
  - Parity mismatch: pulse `parity_err`. The byte is discarded.
  - Good byte with `valid`=0, or with `valid && ready` in the same cycle: load `data_out` and set `valid`.
  - Good byte with `valid`=1 and `ready`=0: pulse `overrun`. The new byte is dropped and the old byte and `valid` are kept.
- `valid` clears on the cycle after `valid && ready`, unless it is reloaded in that same cycle.
- Reset mid-frame: the state returns to IDLE, the partial byte is discarded, and no error pulse is generated.

## Timing
- Reset values:
  - `data_out`=0x00, `valid`=0, `frame_err`=0, `overrun`=0, `busy`=0, `parity_err`=0.
  - Synchroniser=1. Counters=0.
- Let T0 be the cycle in which IDLE sees `rx_s`=0. This is 2–3 cycles after the pin falls.
- Phase-k tick of bit n (start=0, data=1..8, parity=9 when enabled, stop=9 or 10) occurs at T0 + (16n+k+1)·OVS_DIV.
- `valid`, `frame_err` and `overrun` are registered. They appear 1 cycle after the stop-bit phase-9 tick.
  - Without parity: T0 + 154·OVS_DIV + 1.
  - With parity: T0 + 170·OVS_DIV + 1.
- Error pulses are exactly one cycle wide.
- `busy` rises at T0+1 and falls together with the evaluation cycle.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- Defined:
  - PARITY state is present. Even parity is checked over the 8 data bits.
  - Port `parity_err` (output 1) is a one-cycle pulse on mismatch, and the byte is discarded.
- Undefined:
  - No PARITY state.
  - The `parity_err` port is absent. The frame is 10 bits.

## Test plan
- Send 0xA5 at BAUD with `ready`=1 → `valid` pulses with `data_out`=0xA5 at T0+154·OVS_DIV+1. No error pulses.
- Low glitch on `rx` of 4 cycles while idle → START aborts at phase 9 and returns to IDLE. No `valid` and no errors.
- Send 0x3C with stop bit forced to 0 → `frame_err` pulses once, `valid` stays 0, and the next frame 0x81 is received correctly.
- Hold `ready`=0 and send 0x11 then 0x22 → `valid`=1 with 0x11, `overrun` pulses at the second frame, and `data_out` stays 0x11. Raising `ready` for one cycle then clears `valid`.
- Send back-to-back 0x00, 0xFF, 0x55 with no idle gap → all three bytes delivered in order.
- Assert `reset` for one cycle during data bit 4 of a frame → outputs at reset values and no `valid` for that frame. The following frame 0x7E is received.
- With `UART_RX_PARITY_EN`, send 0x07 with parity bit 0 → `parity_err` pulses and no `valid`. With parity bit 1 → 0x07 is delivered.
